div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the ALU and consumes the operand pair the ALU receives.
- Each iteration is one trial subtraction on the carry-chain subtractor `sub`.
- The pipeline stalls while the unit is busy; the result is written back when out_valid pulses.

Parameters:
- N, 32, operand/result width in bits. Only 32 is verified.

Ports:
- clk        input   1   clock, rising edge
- rst_n      input   1   synchronous active-low reset
- in_valid   input   1   request strobe
- in_ready   output  1   unit idle; request accepted when in_valid && in_ready
- op         input   2   instruction funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend   input   N   rs1 value
- divisor    input   N   rs2 value
- kill       input   1   pipeline flush; aborts the operation in flight
- busy       output  1   operation in flight (state != IDLE)
- out_valid  output  1   one-cycle result strobe; no backpressure
- result     output  N   quotient or remainder; held stable until the next accept

Behaviour:
- Reset: rst_n low at a clk edge puts the unit in IDLE. Resulting outputs: in_ready=1, busy=0, out_valid=0, result=0. Reset mid-operation discards all work and produces no out_valid.
- States:
  - IDLE: in_ready=1. On accept, capture op and operands, then branch:
    - divisor==0 -> SPECIAL
    - signed op (DIV/REM) with dividend==0x80000000 and divisor==all-ones -> SPECIAL
    - otherwise -> CALC, with the iteration counter set to N-1
  - CALC: one quotient bit per cycle.
    - Shift {rem,quo} left by 1.
    - trial = {1'b0,rem} - {1'b0,|divisor|} on an (N+1)-bit `sub`.
    - trial MSB==0: rem=trial[N-1:0] and set quotient LSB. Otherwise restore (keep rem) and clear quotient LSB.
    - Counter decrements each cycle; after the counter==0 iteration -> FIX. CALC lasts exactly N cycles.
  - FIX:
    - Signed ops: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
    - Load result (quotient for op[1]==0, remainder for op[1]==1). Assert out_valid for one cycle, then -> IDLE.
  - SPECIAL: load the special result, assert out_valid, then -> IDLE.
    - Divide by zero: quotient = all-ones (DIV and DIVU); remainder = dividend.
    - Signed overflow: quotient = 0x80000000; remainder = 0.
- Latency:
  - Normal path: accept at edge T, out_valid high during the cycle after edge T+N+1 (34 cycles for N=32).
  - Special path: out_valid high during the cycle after edge T+1.
- Back-to-back: in_ready rises in the cycle after out_valid, so the minimum accept spacing is 35 cycles. An in_valid seen while busy is ignored; the requester holds it.
- Kill:
  - Sampled in any non-IDLE state; next state is IDLE and out_valid stays 0. kill outranks entering FIX/SPECIAL output.
  - In IDLE, kill overrides in_valid: nothing is accepted.
  - result keeps its previous value on an abort.
- Operand magnitudes: |x| is the two's complement negate for signed ops when the MSB is set. 0x80000000 maps to 0x80000000 unsigned, which is correct for the unsigned core.
- Edge arithmetic: dividend < divisor (unsigned magnitude) gives quotient 0 and remainder = dividend, with no special case.

Decomposition:
- Shared CPU package holds:
  - Op encodings: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
  - State enum: IDLE, CALC, FIX, SPECIAL.
  - Constant XLEN=32.
- Sub-module: instance of the team's existing subtractor `sub` with N+1 for the trial subtraction. Negations use the same `sub` with a zero minuend (two further instances).
- Counter and FSM stay in div_unit.

Test Plan:
- DIVU 100/7 -> out_valid exactly 34 cycles after accept, result=14; REMU same operands -> 2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1); REM 7/0xFFFFFFFE(-2) -> 1.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - All four take 2-cycle latency.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU same operands -> 0x00000000 via the normal 34-cycle path.
- Kill at cycle 10 of CALC -> no out_valid; in_ready=1 next cycle; a following DIVU 9/3 returns 3 normally.
- rst_n low mid-CALC -> busy=0, out_valid=0, result=0 next cycle. A request held during busy is accepted only once, after return to IDLE.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the M-extension divider: op encodings, FSM states
// and the classification of signed operations.
package div_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    SPECIAL
  } div_state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/div_unit_sub.sv
// Team carry-chain subtractor: diff_o = a_i - b_i (modulo 2^W).
module sub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o
);

  assign diff_o = a_i + ~b_i + W'(1);

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; one quotient bit
// per cycle on an unsigned magnitude core, with the signs applied afterwards.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for a request; in_ready high unless a result is showing
// CALC    | N trial-subtraction iterations, counter counts N-1 down to 0
// FIX     | apply operand signs, load result, pulse out_valid
// SPECIAL | divide-by-zero / signed overflow: load fixed result, pulse out_valid
module div_unit
  import div_unit_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         kill,
  output logic         busy,
  output logic         out_valid,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG  = {1'b1, {(N-1){1'b0}}};

  div_state_e state_q, state_d;

  logic          rem_sel_q, rem_sel_d;
  logic          dvd_neg_q, dvd_neg_d;
  logic          dvs_neg_q, dvs_neg_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;

  // The two negators are shared: operand magnitudes in IDLE, sign fix in FIX.
  logic [N-1:0] neg0_in, neg1_in, neg0, neg1;
  logic [N:0]   trial;

  assign neg0_in = (state_q == IDLE) ? dividend : quo_q;
  assign neg1_in = (state_q == IDLE) ? divisor  : rem_q;

  sub #(.W(N)) u_neg0 (
    .a_i   ('0),
    .b_i   (neg0_in),
    .diff_o(neg0)
  );

  sub #(.W(N)) u_neg1 (
    .a_i   ('0),
    .b_i   (neg1_in),
    .diff_o(neg1)
  );

  // Partial remainder kept N+1 bits wide so a shifted-out MSB is not lost.
  sub #(.W(N + 1)) u_trial (
    .a_i   ({rem_q, quo_q[N-1]}),
    .b_i   ({1'b0, dvs_q}),
    .diff_o(trial)
  );

  logic         sgn_in, dvd_neg_in, dvs_neg_in, div_zero, ovf, accept;
  logic [N-1:0] dvd_mag, dvs_mag;

  assign sgn_in     = is_signed_op(op);
  assign dvd_neg_in = sgn_in & dividend[N-1];
  assign dvs_neg_in = sgn_in & divisor[N-1];
  assign dvd_mag    = dvd_neg_in ? neg0 : dividend;
  assign dvs_mag    = dvs_neg_in ? neg1 : divisor;
  assign div_zero   = (divisor == '0);
  assign ovf        = sgn_in && (dividend == MIN_NEG) && (divisor == '1);
  assign accept     = in_valid && in_ready && !kill;

  always_comb begin
    state_d     = state_q;
    rem_sel_d   = rem_sel_q;
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_sel_d = op[1];
          dvd_neg_d = dvd_neg_in;
          dvs_neg_d = dvs_neg_in;
          dvs_d     = dvs_mag;
          quo_d     = dvd_mag;
          rem_d     = '0;
          cnt_d     = CNT_INIT;
          // rem_q carries the precomputed answer into SPECIAL
          if (div_zero) begin
            rem_d   = op[1] ? dividend : '1;
            state_d = SPECIAL;
          end else if (ovf) begin
            rem_d   = op[1] ? '0 : MIN_NEG;
            state_d = SPECIAL;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (trial[N]) begin
            rem_d = {rem_q[N-2:0], quo_q[N-1]};
            quo_d = {quo_q[N-2:0], 1'b0};
          end else begin
            rem_d = trial[N-1:0];
            quo_d = {quo_q[N-2:0], 1'b1};
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (rem_sel_q) begin
            result_d = dvd_neg_q ? neg1 : rem_q;
          end else begin
            result_d = (dvd_neg_q ^ dvs_neg_q) ? neg0 : quo_q;
          end
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end

      SPECIAL: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          result_d    = rem_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_sel_q   <= 1'b0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_sel_q   <= rem_sel_d;
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The result strobe cycle still counts as occupied for new requests.
  assign in_ready  = (state_q == IDLE) && !out_valid_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
